// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit.
// The optional accumulate opcodes (8-11) are built only under MDU_MADD_EN.
package mdu_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned OP_W            = 4;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [OP_W-1:0] OP_MULT  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd3;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd4;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd8;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd9;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd10;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd11;

  // 64-bit HI/LO payload
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdu_res_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for mult/div (and, under MDU_MADD_EN,
// multiply-accumulate). Undefined codes pass HI/LO through unchanged.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]   MDUOP,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] HI,
  input  logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] rhi,
  output logic [DATA_W-1:0] rlo,
  output logic              divzero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic [DATA_W-1:0]  div_b;
  logic [DATA_W-1:0]  a_mag, b_mag, q_mag, r_mag;
  logic [DATA_W-1:0]  q_s, r_s, q_u, r_u;

  assign prod_s = 64'($signed(A)) * 64'($signed(B));
  assign prod_u = 64'(A) * 64'(B);

  assign divzero = (B == '0) && ((MDUOP == OP_DIV) || (MDUOP == OP_DIVU));

  // Divisor forced to 1 on divide-by-zero so the datapath never sees x/0
  assign div_b = (B == '0) ? DATA_W'(1) : B;

  // Signed divide on magnitudes; this also yields 0x80000000 / -1 = 0x80000000
  assign a_mag = A[DATA_W-1]     ? DATA_W'(0) - A     : A;
  assign b_mag = div_b[DATA_W-1] ? DATA_W'(0) - div_b : div_b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (A[DATA_W-1] ^ div_b[DATA_W-1]) ? DATA_W'(0) - q_mag : q_mag;
  assign r_s   = A[DATA_W-1] ? DATA_W'(0) - r_mag : r_mag;

  assign q_u = A / div_b;
  assign r_u = A % div_b;

  always_comb begin
    rhi = HI;
    rlo = LO;
    case (MDUOP)
      OP_MULT:  {rhi, rlo} = prod_s;
      OP_MULTU: {rhi, rlo} = prod_u;
      OP_DIV:   if (!divzero) begin rhi = r_s; rlo = q_s; end
      OP_DIVU:  if (!divzero) begin rhi = r_u; rlo = q_u; end
`ifdef MDU_MADD_EN
      OP_MADD:  {rhi, rlo} = {HI, LO} + prod_s;
      OP_MADDU: {rhi, rlo} = {HI, LO} + prod_u;
      OP_MSUB:  {rhi, rlo} = {HI, LO} - prod_s;
      OP_MSUBU: {rhi, rlo} = {HI, LO} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div ops.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (codes 8-11).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   MDUOP,
  input  logic              start,
  input  logic              Req,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] MDUOut,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  logic              acc;
  logic              long_op;
  logic              div_op;
  logic [CNT_W-1:0]  lat;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] calc_hi, calc_lo;
  logic              divzero;
  mdu_res_t          pend;
  logic              pend_ok;

  mdu_calc u_calc (
    .MDUOP   (MDUOP),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .rhi     (calc_hi),
    .rlo     (calc_lo),
    .divzero (divzero)
  );

  assign acc = start & ~Req & ~busy;

  // Classify the opcode into multi-cycle kinds and pick its latency
  always_comb begin
    long_op = 1'b0;
    div_op  = 1'b0;
    case (MDUOP)
      OP_MULT, OP_MULTU: long_op = 1'b1;
      OP_DIV, OP_DIVU: begin
        long_op = 1'b1;
        div_op  = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
      default: ;
    endcase
    lat = div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // Counter, busy flag, pending result and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      pend    <= '0;
      pend_ok <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (pend_ok) begin
          HI <= pend.hi;
          LO <= pend.lo;
        end
      end
    end else if (acc) begin
      if (long_op) begin
        cnt     <= lat;
        busy    <= 1'b1;
        pend    <= '{hi: calc_hi, lo: calc_lo};
        pend_ok <= ~divzero;
      end else if (MDUOP == OP_MTLO) begin
        LO <= A;
      end else if (MDUOP == OP_MTHI) begin
        HI <= A;
      end
    end
  end

  // A read during a commit edge sees the pre-commit register value
  assign MDUOut = (MDUOP == OP_MFHI) ? HI : LO;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed plan cases plus randomized ops
// against a plain-arithmetic HI/LO model. Honors MDU_MADD_EN when defined.
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOP;
  logic        start;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_ok;
  int          m_left;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDUOP  (MDUOP),
    .start  (start),
    .Req    (Req),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .MDUOut (MDUOut),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op <= 4'd3) || (op >= 4'd8 && op <= 4'd11);
`else
    return op <= 4'd3;
`endif
  endfunction

  // {HI,LO} result from plain arithmetic; ok=0 means leave HI/LO alone
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo, output bit ok);
    longint sa, sb, q, r;
    longint unsigned ua, ub, acc64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc64 = {hi, lo};
    ok = 1'b1;
    ref_result = {hi, lo};
    case (op)
      4'd0: ref_result = sa * sb;
      4'd1: ref_result = ua * ub;
      4'd2: if (b == 0) ok = 1'b0;
            else begin
              q = sa / sb;
              r = sa % sb;
              ref_result = {r[31:0], q[31:0]};
            end
      4'd3: if (b == 0) ok = 1'b0;
            else ref_result = {32'(ua % ub), 32'(ua / ub)};
      4'd8:  ref_result = acc64 + sa * sb;
      4'd9:  ref_result = acc64 + ua * ub;
      4'd10: ref_result = acc64 - sa * sb;
      4'd11: ref_result = acc64 - ua * ub;
      default: ;
    endcase
  endfunction

  // One clock: drive inputs, check the combinational read, clock, check state
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit st, input bit rq);
    bit ok;
    MDUOP = op; A = a; B = b; start = st; Req = rq;
    #1;
    chk("mduout", 64'(MDUOut), 64'((op == 4'd5) ? m_hi : m_lo));
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) {m_hi, m_lo} = m_pend;
    end else if (st && !rq) begin
      if (is_long(op)) begin
        m_pend = ref_result(op, a, b, m_hi, m_lo, ok);
        m_ok   = ok;
        m_left = (op == 4'd2 || op == 4'd3) ? DIV_N : MULT_N;
      end else if (op == 4'd6) m_lo = a;
      else if (op == 4'd7) m_hi = a;
    end
    #1;
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("hi", 64'(HI), 64'(m_hi));
    chk("lo", 64'(LO), 64'(m_lo));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd4, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    @(posedge clk);
    m_hi = '0; m_lo = '0; m_left = 0; m_ok = 1'b0; m_pend = '0;
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [6];
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    reset = 1'b1; MDUOP = 4'd4; start = 1'b0; Req = 1'b0; A = '0; B = '0;
    m_hi = '0; m_lo = '0; m_left = 0; m_ok = 1'b0; m_pend = '0;
    do_reset();

    step(4'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    idle(MULT_N);
    chk("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFE);

    step(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    idle(MULT_N);
    chk("multu_hi", 64'(HI), 64'h1);
    chk("multu_lo", 64'(LO), 64'hFFFF_FFFE);

    step(4'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    idle(DIV_N - 1);
    chk("div_busy_last", 64'(busy), 64'(1));
    idle(1);
    chk("div_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(HI), 64'hFFFF_FFFF);

    step(4'd3, 32'd7, 32'd2, 1'b1, 1'b0);
    idle(DIV_N);
    chk("divu_lo", 64'(LO), 64'd3);
    chk("divu_hi", 64'(HI), 64'd1);

    step(4'd7, 32'hAAAA0000, 32'd0, 1'b1, 1'b0);
    step(4'd6, 32'h0000BBBB, 32'd0, 1'b1, 1'b0);
    step(4'd2, 32'd5, 32'd0, 1'b1, 1'b0);
    idle(DIV_N);
    chk("div0_hi", 64'(HI), 64'hAAAA_0000);
    chk("div0_lo", 64'(LO), 64'h0000_BBBB);

    step(4'd6, 32'h12345678, 32'd0, 1'b1, 1'b0);
    MDUOP = 4'd4; #1;
    chk("mflo", 64'(MDUOut), 64'h1234_5678);
    step(4'd7, 32'h55, 32'd0, 1'b1, 1'b1);
    chk("mthi_req", 64'(HI), 64'hAAAA_0000);
    step(4'd0, 32'd3, 32'd3, 1'b1, 1'b1);
    chk("mult_req_busy", 64'(busy), 64'(0));

    step(4'd2, 32'd100, 32'd7, 1'b1, 1'b0);
    idle(3);
    do_reset();
    idle(DIV_N);
    chk("abort_hi", 64'(HI), 64'(0));
    chk("abort_lo", 64'(LO), 64'(0));

    step(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    step(4'd0, 32'd9, 32'd9, 1'b1, 1'b0);
    idle(MULT_N - 1);
    chk("ign_lo", 64'(LO), 64'd12);
    chk("ign_busy", 64'(busy), 64'(0));

    step(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(DIV_N);
    chk("ovf_lo", 64'(LO), 64'h8000_0000);
    chk("ovf_hi", 64'(HI), 64'(0));

`ifdef MDU_MADD_EN
    step(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    step(4'd6, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    step(4'd9, 32'd1, 32'd1, 1'b1, 1'b0);
    idle(MULT_N);
    chk("maddu_hi", 64'(HI), 64'd1);
    chk("maddu_lo", 64'(LO), 64'd0);
    step(4'd6, 32'd0, 32'd0, 1'b1, 1'b0);
    step(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    step(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
    idle(MULT_N);
    chk("msub_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("msub_lo", 64'(LO), 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    idle(DIV_N + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes the MDUOP codes produced by the control unit's E-stage decode.
- Owns the HI/LO registers and runs mult/multu/div/divu over a fixed number of cycles.
- Raises `busy` so that hazard logic can stall later HI/LO users.
- Serves mfhi/mflo reads combinationally.
- Accepts mthi/mtlo writes; new operations are suppressed when an exception or interrupt request is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- MDUOP  input  4  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFLO, 5 MFHI, 6 MTLO, 7 MTHI
- start  input  1  E-stage instruction is an MDU instruction; qualifies MDUOP
- Req  input  1  exception/interrupt request this cycle; suppresses acceptance
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  multi-cycle operation in progress
- MDUOut  output  32  HI when MDUOP==MFHI, otherwise LO (combinational)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (synchronous, active-high, wins over everything): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; no later HI/LO update.
- Accept condition: `acc = start & ~Req & ~busy`.
  - start while busy is ignored; the external stall guarantees this never happens.
  - start with Req is ignored entirely.
- Op 0-3 accepted at edge t0:
  - The 64-bit result is computed from A/B sampled at t0 and held in an internal {rhi,rlo}.
  - counter loads MULT_CYCLES or DIV_CYCLES; busy=1 from t0.
  - Counter decrements each edge. At the edge where the counter goes 1->0: HI<=rhi, LO<=rlo, busy<=0.
  - busy therefore stays high for exactly N cycles, and HI/LO hold their old values throughout.
- Arithmetic:
  - MULT: signed 32x32->64, {HI,LO}=product.
  - MULTU: unsigned 32x32->64, {HI,LO}=product.
  - DIV: LO=quotient truncated toward zero; HI=remainder, which takes the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: full busy period runs, then HI/LO are left unchanged.
- Op 6/7 accepted: LO (6) or HI (7) is written from A at the same edge. No busy; no counter effect.
- Op 4/5: no state change. MDUOut reads the current HI/LO.
  - A read in the cycle when HI/LO is being written returns the old value.
  - The hazard unit stalls mf while busy or start are active.
- Codes 8-15 without the optional feature: no-op, busy stays 0.
- HI/LO outputs always reflect the committed registers and never the pending result.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, the block adds:
  - 8 MADD: {HI,LO} += signed A*B
  - 9 MADDU: {HI,LO} += unsigned A*B
  - 10 MSUB: {HI,LO} -= signed A*B
  - 11 MSUBU: {HI,LO} -= unsigned A*B
- These use MULT_CYCLES latency. The accumulator is the {HI,LO} value at t0, with 64-bit wrap-around.
- When undefined: codes 8-15 are no-ops, and no accumulate datapath is synthesized.

Decomposition:
- Package mdu_pkg holds:
  - MDUOP code constants 0-11
  - default latencies
  - counter width (4)
- Sub-module mdu_calc is a purely combinational 64-bit result generator: inputs MDUOP, A, B, HI, LO; outputs rhi, rlo, divzero.
- The mdu top keeps the counter, busy, HI/LO and pending-result registers.

Test Plan:
- MULT, A=0xFFFFFFFF, B=2 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=2 -> LO=3, HI=1.
- DIV with B=0 and HI/LO preloaded to 0xAAAA0000/0x0000BBBB -> busy 10 cycles, registers unchanged afterwards.
- MTLO 0x12345678 -> LO=0x12345678 next cycle; MFLO then gives MDUOut=0x12345678. MTHI with Req=1 -> HI unchanged. MULT with Req=1 -> busy stays 0.
- Reset during busy cycle 4 of DIV -> next cycle busy=0, HI=LO=0, no update at cycle 10. start asserted while busy -> ignored, original result still committed on schedule.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> after 5 cycles HI=1, LO=0. MSUB A=1, B=1 from {0,0} -> HI=LO=0xFFFFFFFF.
